// File: rtl/fft64_sdf_ctrl.sv
// Sequencer for the 64-point radix-2 DIF SDF FFT: input handshake, datapath enable,
// zero padding, per-stage butterfly/twiddle phasing and output framing.
module fft64_sdf_ctrl #(
  parameter int unsigned PIPE = 1,
  parameter int unsigned TW_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              en,
  output logic              din_zero,
  output logic [5:0]        bf_sel,
  output logic [5*TW_W-1:0] tw_addr,
  output logic              out_valid,
  output logic              out_sop,
  output logic [5:0]        out_idx,
  output logic              busy
);

  localparam int unsigned LAT = 63 + 6 * PIPE;

  typedef enum logic [1:0] {StIdle, StRun, StPad, StFlush} state_e;

  state_e           state_q, state_d;
  logic [5:0]       pcnt_q, pcnt_d;
  logic [6:0]       fcnt_q, fcnt_d;
  logic [LAT-1:0]   live_sr_q, live_sr_d;

  logic             rdy;
  logic             accept;
  logic             live;
  logic [5:0]       bf_raw;
  logic [5:0]       ocnt;

  function automatic logic [5:0] stage_off(input int unsigned s);
    int unsigned acc;
    acc = 0;
    for (int unsigned j = 0; j < s; j++) begin
      acc += (32 >> j) + PIPE;
    end
    return acc[5:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StRun;
      end
      StRun: begin
        if (!in_valid) state_d = (pcnt_q != 6'd0) ? StPad : StFlush;
      end
      StPad: begin
        if (pcnt_q == 6'd63) state_d = StFlush;
      end
      StFlush: begin
        if (accept) begin
          state_d = StRun;
        end else if (fcnt_q == 7'd0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake and datapath control outputs
  assign in_ready = rdy & rst_n;
  assign accept   = in_valid & in_ready;

  always_comb begin
    rdy      = 1'b0;
    en       = 1'b0;
    din_zero = 1'b0;
    live     = 1'b0;
    case (state_q)
      StIdle: begin
        rdy  = 1'b1;
        en   = accept;
        live = accept;
      end
      StRun: begin
        rdy      = 1'b1;
        en       = 1'b1;
        din_zero = ~in_valid;
        live     = in_valid | (pcnt_q != 6'd0);
      end
      StPad: begin
        en       = 1'b1;
        din_zero = 1'b1;
        live     = 1'b1;
      end
      StFlush: begin
        rdy      = (pcnt_q == 6'd0);
        en       = 1'b1;
        // A sample accepted while draining is real data, not padding.
        din_zero = ~accept;
        live     = accept;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);

  // Counters and liveness pipeline, all frozen while en is low
  always_comb begin
    pcnt_d    = pcnt_q;
    fcnt_d    = fcnt_q;
    live_sr_d = live_sr_q;
    if (en) begin
      pcnt_d    = pcnt_q + 6'd1;
      live_sr_d = {live_sr_q[LAT-2:0], live};
      case (state_q)
        StRun: begin
          if (!in_valid && pcnt_q == 6'd0) fcnt_d = 7'(LAT - 2);
        end
        StPad: begin
          if (pcnt_q == 6'd63) fcnt_d = 7'(LAT - 1);
        end
        StFlush: begin
          if (!accept) begin
            if (fcnt_q == 7'd0) begin
              pcnt_d = 6'd0;
            end else begin
              fcnt_d = fcnt_q - 7'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q    <= '0;
      fcnt_q    <= '0;
      live_sr_q <= '0;
    end else begin
      pcnt_q    <= pcnt_d;
      fcnt_q    <= fcnt_d;
      live_sr_q <= live_sr_d;
    end
  end

  // Per-stage phase: only the bits each stage consumes are kept
  for (genvar s = 0; s < 6; s++) begin : g_stage
    localparam logic [5:0] Off = stage_off(s);
    logic [5-s:0] cnt;
    assign cnt = (6 - s)'(pcnt_q - Off);
    assign bf_raw[s] = cnt[5-s];
    if (s < 5) begin : g_tw
      logic [TW_W-1:0] tw_v;
      assign tw_v = TW_W'(cnt[4-s:0]) << s;
      assign tw_addr[TW_W*s +: TW_W] = bf_raw[s] ? '0 : tw_v;
    end
  end

  // Butterflies held in pass mode while the datapath is stalled
  assign bf_sel = en ? bf_raw : 6'd0;

  // Output framing
  assign ocnt      = pcnt_q - 6'(LAT);
  assign out_valid = en & live_sr_q[LAT-1];
  assign out_sop   = out_valid & (ocnt == 6'd0);

  always_comb begin
    out_idx = '0;
    for (int i = 0; i < 6; i++) begin
      out_idx[i] = ocnt[5-i];
    end
  end

endmodule
